// File: rtl/biquad8_pole_coeff_loader_pkg.sv
// Shared biquad8 constants and small helpers for the pole-stage coefficient loader.
package biquad8_pole_coeff_loader_pkg;

  localparam int unsigned BQ8_CWIDTH      = 18;
  localparam int unsigned BQ8_POLE_NCOEFF = 4;
  localparam int unsigned BQ8_POLE_AWIDTH = 2;

  // Width of a down-counter that must hold n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/biquad8_pole_coeff_loader.sv
// Coefficient loader for the biquad8 pole IIR: host writes a shadow bank,
// a commit snapshots it and shifts it last-DSP-first through the B1 cascade
// (CEB1), then a single CEB2 pulse switches every DSP at once.
module biquad8_pole_coeff_loader
  import biquad8_pole_coeff_loader_pkg::*;
#(
  parameter int unsigned NCOEFF = BQ8_POLE_NCOEFF,
  parameter int unsigned CWIDTH = BQ8_CWIDTH,
  parameter int unsigned AWIDTH = BQ8_POLE_AWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] host_addr_i,
  input  logic [CWIDTH-1:0] host_dat_i,
  input  logic              host_wr_i,
  input  logic              host_commit_i,
  output logic [CWIDTH-1:0] coeff_dat_o,
  output logic              coeff_wr_o,
  output logic              coeff_update_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned CNTW = cnt_width(NCOEFF);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  state_t            state;
  logic [CNTW-1:0]   cnt;
  logic              pending;
  logic [CWIDTH-1:0] shadow   [NCOEFF];
  logic [CWIDTH-1:0] snapshot [NCOEFF];
  logic              addr_ok;

  assign addr_ok = 32'(host_addr_i) < NCOEFF;

  // Shadow bank: host writes accepted in every state, out-of-range addresses dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCOEFF; i++) shadow[i] <= '0;
    end else if (host_wr_i && addr_ok) begin
      shadow[host_addr_i] <= host_dat_i;
    end
  end

  // Load sequencer with registered outputs. The first shifted word is taken
  // straight from shadow at the commit edge, so it equals snapshot[NCOEFF-1].
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      pending        <= 1'b0;
      coeff_dat_o    <= '0;
      coeff_wr_o     <= 1'b0;
      coeff_update_o <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      for (int unsigned i = 0; i < NCOEFF; i++) snapshot[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          coeff_update_o <= 1'b0;
          done_o         <= 1'b0;
          if (host_commit_i) begin
            for (int unsigned i = 0; i < NCOEFF; i++) snapshot[i] <= shadow[i];
            state       <= SHIFT;
            cnt         <= CNTW'(NCOEFF - 1);
            coeff_dat_o <= shadow[NCOEFF-1];
            coeff_wr_o  <= 1'b1;
            busy_o      <= 1'b1;
          end else begin
            coeff_dat_o <= '0;
            coeff_wr_o  <= 1'b0;
            busy_o      <= 1'b0;
          end
        end

        SHIFT: begin
          if (host_commit_i) pending <= 1'b1;
          if (cnt == '0) begin
            state          <= UPDATE;
            coeff_dat_o    <= '0;
            coeff_wr_o     <= 1'b0;
            coeff_update_o <= 1'b1;
            done_o         <= 1'b1;
          end else begin
            cnt         <= cnt - CNTW'(1);
            coeff_dat_o <= snapshot[cnt - CNTW'(1)];
          end
        end

        UPDATE: begin
          coeff_update_o <= 1'b0;
          done_o         <= 1'b0;
          // A commit landing in this very cycle merges with any earlier pending one.
          if (pending || host_commit_i) begin
            for (int unsigned i = 0; i < NCOEFF; i++) snapshot[i] <= shadow[i];
            pending     <= 1'b0;
            state       <= SHIFT;
            cnt         <= CNTW'(NCOEFF - 1);
            coeff_dat_o <= shadow[NCOEFF-1];
            coeff_wr_o  <= 1'b1;
          end else begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end

        default: begin
          state       <= IDLE;
          coeff_dat_o <= '0;
          coeff_wr_o  <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_biquad8_pole_coeff_loader.sv
// Bench for biquad8_pole_coeff_loader: a 4-DSP and a 3-DSP instance share the
// host bus and are compared every cycle against a transaction-queue model.
module tb_biquad8_pole_coeff_loader;

  localparam int CW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    addr;
  logic [CW-1:0] dat;
  logic          wr;
  logic          commit;

  logic [CW-1:0] dat4, dat3;
  logic          wr4, upd4, busy4, done4;
  logic          wr3, upd3, busy3, done3;

  always #5 clk = ~clk;

  biquad8_pole_coeff_loader #(.NCOEFF(4), .CWIDTH(CW), .AWIDTH(2)) dut (
    .clk(clk), .rst(rst), .host_addr_i(addr), .host_dat_i(dat),
    .host_wr_i(wr), .host_commit_i(commit),
    .coeff_dat_o(dat4), .coeff_wr_o(wr4), .coeff_update_o(upd4),
    .busy_o(busy4), .done_o(done4)
  );

  biquad8_pole_coeff_loader #(.NCOEFF(3), .CWIDTH(CW), .AWIDTH(2)) dut3 (
    .clk(clk), .rst(rst), .host_addr_i(addr), .host_dat_i(dat),
    .host_wr_i(wr), .host_commit_i(commit),
    .coeff_dat_o(dat3), .coeff_wr_o(wr3), .coeff_update_o(upd3),
    .busy_o(busy3), .done_o(done3)
  );

  // Reference model: each accepted commit enqueues the words the cascade
  // should see (last DSP first) followed by one update slot.
  typedef struct packed {
    logic          wr;
    logic          upd;
    logic [CW-1:0] dat;
  } ent_t;

  ent_t          q    [2][8];
  int            qlen [2];
  ent_t          cur  [2];
  logic [CW-1:0] sh   [2][4];
  logic          pend [2];
  int            n    [2] = '{4, 3};

  logic [CW-1:0] b1 [4];
  logic [CW-1:0] b2 [4];

  int passed = 0;
  int total  = 0;
  int done_cnt, wr3_cnt, upd_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push_seq(input int m);
    for (int i = n[m] - 1; i >= 0; i--) begin
      q[m][qlen[m]] = '{wr: 1'b1, upd: 1'b0, dat: sh[m][i]};
      qlen[m]++;
    end
    q[m][qlen[m]] = '{wr: 1'b0, upd: 1'b1, dat: '0};
    qlen[m]++;
  endtask

  task automatic model_edge(input int m);
    logic idle;
    if (rst) begin
      qlen[m] = 0;
      cur[m]  = '0;
      pend[m] = 1'b0;
      for (int i = 0; i < 4; i++) sh[m][i] = '0;
      return;
    end
    idle = (qlen[m] == 0) && !cur[m].wr && !cur[m].upd;
    if (idle) begin
      if (commit) push_seq(m);
    end else begin
      if (commit) pend[m] = 1'b1;
      if (cur[m].upd && pend[m]) begin
        push_seq(m);
        pend[m] = 1'b0;
      end
    end
    if (wr && (int'(addr) < n[m])) sh[m][addr] = dat;
    if (qlen[m] > 0) begin
      cur[m] = q[m][0];
      for (int i = 0; i < 7; i++) q[m][i] = q[m][i+1];
      qlen[m]--;
    end else begin
      cur[m] = '0;
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, check on the falling edge.
  task automatic step(input logic r, input logic w, input logic [1:0] a,
                      input logic [CW-1:0] d, input logic c);
    rst = r; wr = w; addr = a; dat = d; commit = c;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    chk("dut4.dat",  32'(dat4),  32'(cur[0].dat));
    chk("dut4.wr",   32'(wr4),   32'(cur[0].wr));
    chk("dut4.upd",  32'(upd4),  32'(cur[0].upd));
    chk("dut4.done", 32'(done4), 32'(cur[0].upd));
    chk("dut4.busy", 32'(busy4), 32'(cur[0].wr | cur[0].upd));
    chk("dut3.dat",  32'(dat3),  32'(cur[1].dat));
    chk("dut3.wr",   32'(wr3),   32'(cur[1].wr));
    chk("dut3.upd",  32'(upd3),  32'(cur[1].upd));
    chk("dut3.done", 32'(done3), 32'(cur[1].upd));
    chk("dut3.busy", 32'(busy3), 32'(cur[1].wr | cur[1].upd));
    if (wr4) begin
      for (int i = 3; i > 0; i--) b1[i] = b1[i-1];
      b1[0] = dat4;
    end
    if (upd4) for (int i = 0; i < 4; i++) b2[i] = b1[i];
    if (done4) done_cnt++;
    if (upd4) upd_cnt++;
    if (wr3) wr3_cnt++;
    rst = 1'b0; wr = 1'b0; commit = 1'b0;
  endtask

  task automatic idle_steps(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 2'd0, '0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; addr = '0; dat = '0; commit = 1'b0;
    for (int m = 0; m < 2; m++) begin
      qlen[m] = 0; cur[m] = '0; pend[m] = 1'b0;
      for (int i = 0; i < 4; i++) sh[m][i] = '0;
    end
    for (int i = 0; i < 4; i++) begin b1[i] = '0; b2[i] = '0; end
    done_cnt = 0; wr3_cnt = 0; upd_cnt = 0;

    // Reset state
    step(1'b1, 1'b0, 2'd0, '0, 1'b0);
    step(1'b1, 1'b0, 2'd0, '0, 1'b0);
    idle_steps(2);

    // Load order and B1/B2 cascade result
    step(1'b0, 1'b1, 2'd0, 18'h00011, 1'b0);
    step(1'b0, 1'b1, 2'd1, 18'h00022, 1'b0);
    step(1'b0, 1'b1, 2'd2, 18'h00033, 1'b0);
    step(1'b0, 1'b1, 2'd3, 18'h00044, 1'b0);
    step(1'b0, 1'b0, 2'd0, '0, 1'b1);
    idle_steps(7);
    for (int k = 0; k < 4; k++) chk("cascade.load", 32'(b2[k]), 32'(18'h00011 * (k + 1)));

    // Write during busy: current load keeps 0x22, next load carries 0x3FFFF
    step(1'b0, 1'b0, 2'd0, '0, 1'b1);
    idle_steps(1);
    step(1'b0, 1'b1, 2'd1, 18'h3FFFF, 1'b0);
    idle_steps(5);
    chk("cascade.wr_busy_old", 32'(b2[1]), 32'h22);
    step(1'b0, 1'b0, 2'd0, '0, 1'b1);
    idle_steps(7);
    chk("cascade.wr_busy_new", 32'(b2[1]), 32'h3FFFF);

    // Commit while busy: two back-to-back loads, two done pulses
    done_cnt = 0;
    step(1'b0, 1'b0, 2'd0, '0, 1'b1);
    idle_steps(2);
    step(1'b0, 1'b0, 2'd0, '0, 1'b1);
    idle_steps(10);
    chk("done.pulses", 32'(done_cnt), 32'd2);

    // Simultaneous write + commit: snapshot keeps old addr0
    step(1'b0, 1'b1, 2'd0, 18'h12345, 1'b1);
    idle_steps(7);
    chk("cascade.same_cycle_old", 32'(b2[0]), 32'h11);
    step(1'b0, 1'b0, 2'd0, '0, 1'b1);
    idle_steps(7);
    chk("cascade.same_cycle_new", 32'(b2[0]), 32'h12345);

    // Reset mid-SHIFT: no update pulse, B2 untouched, next load is all zeros
    upd_cnt = 0;
    step(1'b0, 1'b0, 2'd0, '0, 1'b1);
    idle_steps(1);
    step(1'b1, 1'b0, 2'd0, '0, 1'b0);
    idle_steps(6);
    chk("reset.no_update", 32'(upd_cnt), 32'd0);
    chk("reset.b2_kept", 32'(b2[0]), 32'h12345);
    step(1'b0, 1'b0, 2'd0, '0, 1'b1);
    idle_steps(7);
    for (int k = 0; k < 4; k++) chk("cascade.after_reset", 32'(b2[k]), 32'd0);

    // Out-of-range address on the 3-entry instance
    wr3_cnt = 0;
    step(1'b0, 1'b1, 2'd3, 18'h2AAAA, 1'b0);
    step(1'b0, 1'b1, 2'd2, 18'h15555, 1'b0);
    step(1'b0, 1'b0, 2'd0, '0, 1'b1);
    idle_steps(7);
    chk("dut3.wr_cycles", 32'(wr3_cnt), 32'd3);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 1) == 1),
           2'($urandom_range(0, 3)),
           CW'($urandom),
           ($urandom_range(0, 9) == 0));
    end
    idle_steps(12);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/biquad8_pole_coeff_loader.md
Name: biquad8_pole_coeff_loader

Overview:
Sequencer feeding the coefficient write port of the 4-DSP biquad pole IIR. The host writes coefficients by address into a shadow bank, then issues a commit. The block shifts the snapshot into the DSP B-register cascade through CEB1, then pulses CEB2 so all DSPs switch coefficients on the same clock. This guarantees the IIR never runs with a mixed old/new coefficient set.

Parameters:
NCOEFF, 4, number of cascaded DSPs / coefficients; entry k is destined for DSP k (DSP0 = chain head).
CWIDTH, 18, coefficient width; matches the DSP B port.
AWIDTH, 2, host address width; must satisfy 2^AWIDTH >= NCOEFF.

Ports:
clk  in  1  single clock; all logic sits on the rising edge.
rst  in  1  synchronous, active-high reset.
host_addr_i  in  AWIDTH  shadow entry index for a write.
host_dat_i  in  CWIDTH  coefficient value, two's complement.
host_wr_i  in  1  single-cycle write strobe into the shadow bank.
host_commit_i  in  1  request to load the current shadow bank into the IIR.
coeff_dat_o  out  CWIDTH  drives the IIR coeff_dat_i (DSP0 B input).
coeff_wr_o  out  1  drives the IIR coeff_wr_i (CEB1 of every DSP).
coeff_update_o  out  1  drives the IIR coeff_update_i (CEB2 of every DSP).
busy_o  out  1  high while a load sequence is in progress.
done_o  out  1  one-cycle pulse on the cycle coeff_update_o is high.

Behaviour:
- Reset: shadow and snapshot banks cleared to 0; state IDLE; pending flag cleared.
- Reset values: coeff_dat_o=0, coeff_wr_o=0, coeff_update_o=0, busy_o=0, done_o=0.
- Reset mid-sequence aborts the load. No coeff_update_o is issued, so the IIR keeps its old B2 coefficients; B1 contents are don't-care.
- Shadow write: on host_wr_i, shadow[host_addr_i] <= host_dat_i.
  - A write with host_addr_i >= NCOEFF is ignored.
  - Writes are accepted in every state, including during busy.
- Commit is sampled at cycle T in IDLE:
  - snapshot <= shadow. A write in the same cycle T is not included in the snapshot; it lands in shadow only.
  - state -> SHIFT, shift counter = NCOEFF-1.
- SHIFT: cycles T+1 .. T+NCOEFF.
  - coeff_wr_o=1.
  - coeff_dat_o = snapshot[NCOEFF-1], then snapshot[NCOEFF-2], ..., down to snapshot[0]. The last-DSP value goes first, because the B1 cascade shifts one DSP per CEB1.
  - The counter decrements each cycle; at 0, state -> UPDATE.
- UPDATE: cycle T+NCOEFF+1.
  - coeff_wr_o=0, coeff_update_o=1, done_o=1.
  - Next state is IDLE, or SHIFT if the pending flag is set (see below).
- busy_o is high for cycles T+1 .. T+NCOEFF+1 inclusive, low in IDLE.
- coeff_dat_o is held at 0 whenever coeff_wr_o=0.
- Commit while busy:
  - Sets the pending flag; further commits while pending are merged.
  - On leaving UPDATE with pending set: snapshot <= shadow at that cycle, pending cleared, state -> SHIFT directly. No IDLE cycle in between; busy_o stays high.
  - A commit in the UPDATE cycle itself also counts as pending.
- Registering: all outputs are registered; no combinational path from host inputs to outputs.
- Width rule: coefficients pass through unmodified. No scaling or saturation; the fixed-point format is owned by the IIR.

Decomposition:
- Shared header biquad8 constants: coefficient width 18, pole DSP count 4.
- The FSM state encoding (IDLE/SHIFT/UPDATE) is local to the module.
- No sub-module required. Shadow and snapshot are small register arrays inline.
- If the same loader is later reused for the FIR zero stage, NCOEFF is the only change.

Test Plan:
- Load order: write shadow {0:0x00011, 1:0x00022, 2:0x00033, 3:0x00044}, commit at T -> coeff_wr_o high T+1..T+4 with data 0x44, 0x33, 0x22, 0x11. coeff_update_o and done_o at T+5; busy_o T+1..T+5. A 4-DSP B1/B2 cascade model ends with DSP0..3 holding 0x11..0x44.
- Write during busy: commit at T, then write addr1=0x3FFFF at T+2 -> the current sequence still emits 0x22 for DSP1. A second commit then loads 0x3FFFF.
- Commit while busy: commits at T and T+3 -> first update at T+5. Second SHIFT runs T+6..T+9 with busy_o continuously high, second update at T+10; exactly two done_o pulses.
- Simultaneous write + commit in IDLE at T, addr0=0x12345 -> snapshot holds the old addr0 value. A following commit emits 0x12345.
- Reset mid-SHIFT at T+2 -> from T+3 all outputs are 0 and there is no coeff_update_o pulse. A subsequent commit emits all zeros, because the shadow was cleared.
- Out-of-range: with NCOEFF=3, AWIDTH=2, a write to addr3 is ignored. A commit emits exactly 3 wr cycles.
